// File: rtl/tboom_rename_map_table.sv
// 2-wide register rename map table with branch-recovery snapshots.
// Looks up physical sources and stale pdsts for two uops per cycle, with
// intra-bundle bypass from slot 0 to slot 1, and presents results one cycle later.
module tboom_rename_map_table #(
   parameter int unsigned ARCH_REGS        = 32,
   parameter int unsigned PREG_WIDTH       = 6,
   parameter int unsigned CHECKPOINT_DEPTH = 8,
   localparam int unsigned AW              = $clog2(ARCH_REGS),
   localparam int unsigned CW              = $clog2(CHECKPOINT_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i0_valid,
   input  logic [AW-1:0]         i0_rs1,
   input  logic [AW-1:0]         i0_rs2,
   input  logic [AW-1:0]         i0_rd,
   input  logic                  i0_rd_valid,
   input  logic [PREG_WIDTH-1:0] i0_pdst,
   input  logic                  i1_valid,
   input  logic [AW-1:0]         i1_rs1,
   input  logic [AW-1:0]         i1_rs2,
   input  logic [AW-1:0]         i1_rd,
   input  logic                  i1_rd_valid,
   input  logic [PREG_WIDTH-1:0] i1_pdst,
   input  logic                  stall,
   input  logic                  checkpoint,
   input  logic                  restore,
   input  logic [CW-1:0]         checkpoint_restore_pos,
   output logic                  out_valid,
   output logic [PREG_WIDTH-1:0] o0_prs1,
   output logic [PREG_WIDTH-1:0] o0_prs2,
   output logic [PREG_WIDTH-1:0] o0_pdst,
   output logic [PREG_WIDTH-1:0] o0_stale_pdst,
   output logic                  o0_writes,
   output logic [PREG_WIDTH-1:0] o1_prs1,
   output logic [PREG_WIDTH-1:0] o1_prs2,
   output logic [PREG_WIDTH-1:0] o1_pdst,
   output logic [PREG_WIDTH-1:0] o1_stale_pdst,
   output logic                  o1_writes
);

   logic [PREG_WIDTH-1:0] map_q  [ARCH_REGS];
   logic [PREG_WIDTH-1:0] snap_q [CHECKPOINT_DEPTH][ARCH_REGS];

   logic                  w0, w1, accept;
   logic                  out_valid_d;
   logic [PREG_WIDTH-1:0] o0_prs1_d, o0_prs2_d, o0_pdst_d, o0_stale_d;
   logic [PREG_WIDTH-1:0] o1_prs1_d, o1_prs2_d, o1_pdst_d, o1_stale_d;
   logic                  o0_writes_d, o1_writes_d;

   // Decode writes, look up sources against the start-of-cycle map, apply slot-0 bypass.
   always_comb begin
      w0          = i0_valid & i0_rd_valid & (i0_rd != '0);
      w1          = i1_valid & i1_rd_valid & (i1_rd != '0);
      accept      = (i0_valid | i1_valid) & ~stall & ~restore;
      out_valid_d = accept;
      o0_prs1_d   = '0;
      o0_prs2_d   = '0;
      o0_pdst_d   = '0;
      o0_stale_d  = '0;
      o0_writes_d = 1'b0;
      o1_prs1_d   = '0;
      o1_prs2_d   = '0;
      o1_pdst_d   = '0;
      o1_stale_d  = '0;
      o1_writes_d = 1'b0;
      if (accept && i0_valid) begin
         o0_prs1_d   = (i0_rs1 == '0) ? '0 : map_q[i0_rs1];
         o0_prs2_d   = (i0_rs2 == '0) ? '0 : map_q[i0_rs2];
         o0_pdst_d   = i0_pdst;
         o0_stale_d  = w0 ? map_q[i0_rd] : '0;
         o0_writes_d = w0;
      end
      if (accept && i1_valid) begin
         // x0 is never renamed, so a slot-0 write can't alias a zero source
         if (i1_rs1 == '0)             o1_prs1_d = '0;
         else if (w0 && i1_rs1 == i0_rd) o1_prs1_d = i0_pdst;
         else                           o1_prs1_d = map_q[i1_rs1];
         if (i1_rs2 == '0)             o1_prs2_d = '0;
         else if (w0 && i1_rs2 == i0_rd) o1_prs2_d = i0_pdst;
         else                           o1_prs2_d = map_q[i1_rs2];
         o1_pdst_d   = i1_pdst;
         if (w1) o1_stale_d = (w0 && i1_rd == i0_rd) ? i0_pdst : map_q[i1_rd];
         o1_writes_d = w1;
      end
   end

   // Live map: restore wins over rename; slot 1 written last so it wins on equal rd.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < ARCH_REGS; r++) map_q[r] <= PREG_WIDTH'(r);
      end else if (restore) begin
         map_q <= snap_q[checkpoint_restore_pos];
      end else if (accept) begin
         if (w0) map_q[i0_rd] <= i0_pdst;
         if (w1) map_q[i1_rd] <= i1_pdst;
      end
   end

   // Snapshots capture the pre-update map; a same-cycle restore suppresses the capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CHECKPOINT_DEPTH; c++) begin
            for (int r = 0; r < ARCH_REGS; r++) snap_q[c][r] <= PREG_WIDTH'(r);
         end
      end else if (checkpoint && !restore) begin
         snap_q[checkpoint_restore_pos] <= map_q;
      end
   end

   // Registered outputs, valid for exactly one cycle after an accepted bundle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         o0_prs1       <= '0;
         o0_prs2       <= '0;
         o0_pdst       <= '0;
         o0_stale_pdst <= '0;
         o0_writes     <= 1'b0;
         o1_prs1       <= '0;
         o1_prs2       <= '0;
         o1_pdst       <= '0;
         o1_stale_pdst <= '0;
         o1_writes     <= 1'b0;
      end else begin
         out_valid     <= out_valid_d;
         o0_prs1       <= o0_prs1_d;
         o0_prs2       <= o0_prs2_d;
         o0_pdst       <= o0_pdst_d;
         o0_stale_pdst <= o0_stale_d;
         o0_writes     <= o0_writes_d;
         o1_prs1       <= o1_prs1_d;
         o1_prs2       <= o1_prs2_d;
         o1_pdst       <= o1_pdst_d;
         o1_stale_pdst <= o1_stale_d;
         o1_writes     <= o1_writes_d;
      end
   end

endmodule

// File: tb/tb_tboom_rename_map_table.sv
// Bench for tboom_rename_map_table: directed scenarios then random bundles,
// checked by a scoreboard fed from a sequential-rename reference model.
module tb_tboom_rename_map_table;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i0_valid, i0_rd_valid, i1_valid, i1_rd_valid;
   logic [4:0] i0_rs1, i0_rs2, i0_rd, i1_rs1, i1_rs2, i1_rd;
   logic [5:0] i0_pdst, i1_pdst;
   logic       stall, checkpoint, restore;
   logic [2:0] checkpoint_restore_pos;
   logic       out_valid, o0_writes, o1_writes;
   logic [5:0] o0_prs1, o0_prs2, o0_pdst, o0_stale_pdst;
   logic [5:0] o1_prs1, o1_prs2, o1_pdst, o1_stale_pdst;

   tboom_rename_map_table dut (
      .clk(clk), .rst(rst),
      .i0_valid(i0_valid), .i0_rs1(i0_rs1), .i0_rs2(i0_rs2), .i0_rd(i0_rd),
      .i0_rd_valid(i0_rd_valid), .i0_pdst(i0_pdst),
      .i1_valid(i1_valid), .i1_rs1(i1_rs1), .i1_rs2(i1_rs2), .i1_rd(i1_rd),
      .i1_rd_valid(i1_rd_valid), .i1_pdst(i1_pdst),
      .stall(stall), .checkpoint(checkpoint), .restore(restore),
      .checkpoint_restore_pos(checkpoint_restore_pos),
      .out_valid(out_valid),
      .o0_prs1(o0_prs1), .o0_prs2(o0_prs2), .o0_pdst(o0_pdst),
      .o0_stale_pdst(o0_stale_pdst), .o0_writes(o0_writes),
      .o1_prs1(o1_prs1), .o1_prs2(o1_prs2), .o1_pdst(o1_pdst),
      .o1_stale_pdst(o1_stale_pdst), .o1_writes(o1_writes)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic [4:0] rs1, rs2, rd;
      logic       rdv;
      logic [5:0] pdst;
   } uop_t;

   typedef struct packed {
      uop_t       u0, u1;
      logic       stall, ckpt, rest;
      logic [2:0] pos;
   } bund_t;

   typedef struct packed {
      logic [5:0] prs1, prs2, pdst, stale;
      logic       writes;
   } slot_t;

   typedef struct packed {
      logic  valid;
      slot_t s0, s1;
   } exp_t;

   exp_t       q[$];
   logic [5:0] mdl   [32];
   logic [5:0] snaps [8][32];
   int         vectors = 0;
   int         miscompares = 0;

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         mdl[r] = 6'(r);
         for (int c = 0; c < 8; c++) snaps[c][r] = 6'(r);
      end
   endtask

   // Rename one uop against the current model map, updating it in place.
   task automatic rename_uop(input uop_t u, output slot_t s);
      s = '0;
      if (u.v) begin
         s.prs1 = (u.rs1 == 0) ? 6'd0 : mdl[u.rs1];
         s.prs2 = (u.rs2 == 0) ? 6'd0 : mdl[u.rs2];
         s.pdst = u.pdst;
         if (u.rdv && u.rd != 0) begin
            s.stale   = mdl[u.rd];
            s.writes  = 1'b1;
            mdl[u.rd] = u.pdst;
         end
      end
   endtask

   task automatic apply(input bund_t b);
      i0_valid = b.u0.v; i0_rs1 = b.u0.rs1; i0_rs2 = b.u0.rs2; i0_rd = b.u0.rd;
      i0_rd_valid = b.u0.rdv; i0_pdst = b.u0.pdst;
      i1_valid = b.u1.v; i1_rs1 = b.u1.rs1; i1_rs2 = b.u1.rs2; i1_rd = b.u1.rd;
      i1_rd_valid = b.u1.rdv; i1_pdst = b.u1.pdst;
      stall = b.stall; checkpoint = b.ckpt; restore = b.rest;
      checkpoint_restore_pos = b.pos;
   endtask

   // Drive one cycle and queue what the DUT must show after the next edge.
   task automatic issue(input bund_t b);
      exp_t e;
      @(negedge clk);
      apply(b);
      e = '0;
      if (b.rest) begin
         mdl = snaps[b.pos];
      end else begin
         if (b.ckpt) snaps[b.pos] = mdl;
         if (!b.stall && (b.u0.v || b.u1.v)) begin
            e.valid = 1'b1;
            rename_uop(b.u0, e.s0);
            rename_uop(b.u1, e.s1);
         end
      end
      q.push_back(e);
   endtask

   task automatic pulse_reset();
      exp_t e;
      @(negedge clk);
      apply('0);
      rst = 1'b1;
      e = '0;
      q.push_back(e);
      #1;
      vectors++;
      if ({out_valid, o0_prs1, o0_prs2, o0_pdst, o0_stale_pdst, o0_writes,
           o1_prs1, o1_prs2, o1_pdst, o1_stale_pdst, o1_writes} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got valid=%b o0=%h o1=%h, want all zero", out_valid,
                  {o0_prs1, o0_prs2, o0_pdst, o0_stale_pdst, o0_writes},
                  {o1_prs1, o1_prs2, o1_pdst, o1_stale_pdst, o1_writes});
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      q.push_back(e);
   endtask

   function automatic logic [4:0] rand_arch();
      case ($urandom_range(0, 3))
         0:       return 5'd0;
         1, 2:    return 5'($urandom_range(1, 7));
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   function automatic uop_t rand_uop();
      uop_t u;
      u.v    = ($urandom_range(0, 3) != 0);
      u.rs1  = rand_arch();
      u.rs2  = rand_arch();
      u.rd   = rand_arch();
      u.rdv  = ($urandom_range(0, 3) != 0);
      u.pdst = 6'($urandom_range(0, 63));
      return u;
   endfunction

   function automatic uop_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic rdv, input logic [4:0] rd, input logic [5:0] pdst);
      uop_t u;
      u.v = 1'b1; u.rs1 = rs1; u.rs2 = rs2; u.rdv = rdv; u.rd = rd; u.pdst = pdst;
      return u;
   endfunction

   // Monitor: one scoreboard entry per cycle, compared just after the active edge.
   initial begin
      exp_t  e;
      slot_t a0, a1;
      forever begin
         @(posedge clk);
         #1;
         e = (q.size() > 0) ? q.pop_front() : '0;
         a0 = {o0_prs1, o0_prs2, o0_pdst, o0_stale_pdst, o0_writes};
         a1 = {o1_prs1, o1_prs2, o1_pdst, o1_stale_pdst, o1_writes};
         vectors++;
         if (out_valid !== e.valid) begin
            miscompares++;
            $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, e.valid);
         end
         if (e.valid) begin
            vectors += 2;
            if (a0 !== e.s0) begin
               miscompares++;
               $display("FAIL slot0 @%0t: got prs1/prs2/pdst/stale/wr=%h want %h",
                        $time, a0, e.s0);
            end
            if (a1 !== e.s1) begin
               miscompares++;
               $display("FAIL slot1 @%0t: got prs1/prs2/pdst/stale/wr=%h want %h",
                        $time, a1, e.s1);
            end
         end
      end
   end

   initial begin
      bund_t b;
      apply('0);
      model_reset();
      repeat (2) @(negedge clk);
      pulse_reset();

      // 1: plain lookup
      b = '0; b.u0 = mk(5'd5, 5'd0, 1'b0, 5'd0, 6'd0); issue(b);
      // 2: rename x5 then read it back
      b = '0; b.u0 = mk(5'd1, 5'd2, 1'b1, 5'd5, 6'd32); issue(b);
      b = '0; b.u0 = mk(5'd5, 5'd5, 1'b0, 5'd0, 6'd0); issue(b);
      // 3: intra-bundle bypass, same rd in both slots
      b = '0; b.u0 = mk(5'd3, 5'd4, 1'b1, 5'd7, 6'd40);
      b.u1 = mk(5'd7, 5'd7, 1'b1, 5'd7, 6'd41); issue(b);
      b = '0; b.u1 = mk(5'd7, 5'd5, 1'b0, 5'd0, 6'd0); issue(b);
      // 4: rd=x0 never renamed
      b = '0; b.u0 = mk(5'd0, 5'd7, 1'b1, 5'd0, 6'd33); issue(b);
      b = '0; b.u0 = mk(5'd0, 5'd0, 1'b0, 5'd0, 6'd0); issue(b);
      // 5: checkpoint excludes same-cycle write; restore twice gives same map
      b = '0; b.u0 = mk(5'd9, 5'd0, 1'b1, 5'd9, 6'd50); b.ckpt = 1'b1; b.pos = 3'd3; issue(b);
      b = '0; b.u0 = mk(5'd9, 5'd0, 1'b1, 5'd9, 6'd51); issue(b);
      b = '0; b.u0 = mk(5'd9, 5'd0, 1'b1, 5'd9, 6'd52); b.rest = 1'b1; b.ckpt = 1'b1;
      b.pos = 3'd3; issue(b);
      b = '0; b.u0 = mk(5'd9, 5'd7, 1'b1, 5'd9, 6'd53); issue(b);
      b = '0; b.rest = 1'b1; b.pos = 3'd3; issue(b);
      b = '0; b.u0 = mk(5'd9, 5'd5, 1'b0, 5'd0, 6'd0); issue(b);
      // 6: stall blocks the update; reset mid-stream restores identity
      b = '0; b.u0 = mk(5'd1, 5'd2, 1'b1, 5'd4, 6'd34); b.stall = 1'b1; issue(b);
      b = '0; b.u0 = mk(5'd4, 5'd0, 1'b0, 5'd0, 6'd0); issue(b);
      b = '0; b.u0 = mk(5'd4, 5'd5, 1'b1, 5'd6, 6'd35); issue(b);
      pulse_reset();
      b = '0; b.u0 = mk(5'd5, 5'd6, 1'b0, 5'd0, 6'd0);
      b.u1 = mk(5'd7, 5'd9, 1'b0, 5'd0, 6'd0); issue(b);

      // Random traffic with occasional stall/checkpoint/restore and one reset.
      for (int n = 0; n < 600; n++) begin
         b.u0  = rand_uop();
         b.u1  = rand_uop();
         b.stall = ($urandom_range(0, 7) == 0);
         b.ckpt  = ($urandom_range(0, 7) == 0);
         b.rest  = ($urandom_range(0, 15) == 0);
         b.pos   = 3'($urandom_range(0, 7));
         issue(b);
         if (n == 300) pulse_reset();
      end
      b = '0;
      repeat (3) issue(b);
      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
